// File: rtl/sar_adc_ctrl.sv
// Purpose : successive-approximation controller for a WIDTH-bit ladder DAC plus comparator.
// Latency : WIDTH*(SETTLE_CYCLES+1) edges from the accepting edge of start to the done pulse.
// Backpressure: none; start is only sampled in IDLE and is dropped (not queued) while busy.
//
// Ports:
//   clk      rising-edge clock
//   rst      synchronous active-high reset, overrides a conversion in progress
//   start    conversion request (sampled in IDLE only)
//   cmp      comparator: 1 = analog input >= DAC output (keep trial bit), 0 = clear it
//   dac_code code driven to the DAC; changes only on accept and DECIDE edges
//   busy     high from the accepting edge until the completion edge
//   done     one-cycle pulse on the edge that updates result
//   result   last completed conversion, held until the next completion
//
// SETTLE_CYCLES must be >= 1.
module sar_adc_ctrl #(
    parameter int WIDTH         = 4,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             cmp,
    output logic [WIDTH-1:0] dac_code,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    localparam logic [CW-1:0]    CNT_LAST = CW'(SETTLE_CYCLES - 1);
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
    localparam logic [WIDTH-1:0] MSB_CODE = ONE << (WIDTH - 1);
    localparam logic [IW-1:0]    TOP_IDX  = IW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_DECIDE
    } state_t;

    state_t          r_state;
    logic [IW-1:0]   r_bit_idx;
    logic [CW-1:0]   r_cnt;

    // Current code with the trial bit resolved by the comparator. Only feeds
    // registers, so cmp never reaches an output combinationally.
    logic [WIDTH-1:0] w_code;
    // Next lower trial bit; only used while r_bit_idx > 0.
    logic [WIDTH-1:0] w_next_trial;

    always_comb begin
        w_code = dac_code;
        if (!cmp) begin
            w_code[r_bit_idx] = 1'b0;
        end
    end

    assign w_next_trial = ONE << (r_bit_idx - IW'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_bit_idx <= '0;
            r_cnt     <= '0;
            dac_code  <= '0;
            result    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        dac_code  <= MSB_CODE;
                        r_bit_idx <= TOP_IDX;
                        r_cnt     <= '0;
                        busy      <= 1'b1;
                        r_state   <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    // cmp is deliberately ignored while the ladder settles.
                    if (r_cnt == CNT_LAST) begin
                        r_state <= S_DECIDE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_DECIDE: begin
                    if (r_bit_idx != '0) begin
                        dac_code  <= w_code | w_next_trial;
                        r_bit_idx <= r_bit_idx - IW'(1);
                        r_cnt     <= '0;
                        r_state   <= S_SETTLE;
                    end else begin
                        dac_code <= w_code;
                        result   <= w_code;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        r_state  <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// Purpose : self-checking bench for sar_adc_ctrl with an ideal 4-bit ladder and comparator.
// Latency : expects done 12 edges after accept (SETTLE_CYCLES=2) and 8 edges (SETTLE_CYCLES=1).
// Backpressure: n/a; exercises start-while-busy, start held high and mid-conversion reset.
//
// Voltages are in millivolts with vref = 1200 mV; ladder level i is i*1200/15 mV,
// so the comparison vin >= level is done exactly as vin*15 >= i*1200.
module tb_sar_adc_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, start1;
    logic       cmp, cmp1;
    logic [3:0] dac_code, dac_code1;
    logic       busy, busy1;
    logic       done, done1;
    logic [3:0] result, result1;

    int   vin_mv  = 0;
    int   vin1_mv = 0;
    logic corrupt1 = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    assign cmp  = (vin_mv * 15 >= int'(dac_code) * 1200);
    assign cmp1 = (vin1_mv * 15 >= int'(dac_code1) * 1200) ^ corrupt1;

    sar_adc_ctrl #(.WIDTH(4), .SETTLE_CYCLES(2)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .cmp      (cmp),
        .dac_code (dac_code),
        .busy     (busy),
        .done     (done),
        .result   (result)
    );

    sar_adc_ctrl #(.WIDTH(4), .SETTLE_CYCLES(1)) u_dut1 (
        .clk      (clk),
        .rst      (rst),
        .start    (start1),
        .cmp      (cmp1),
        .dac_code (dac_code1),
        .busy     (busy1),
        .done     (done1),
        .result   (result1)
    );

    typedef struct {
        int         vin_mv;
        logic [3:0] exp;
    } vec_t;

    vec_t vecs[19];

    logic [3:0] trace[0:20];
    logic [3:0] seq[0:4];
    int         done_at;
    int         n_dones;
    logic       busy_ok;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // One conversion on u_dut; optional extra start pulse at edge pulse_at.
    task automatic run_conv(input int vin, input int pulse_at);
        vin_mv = vin;
        start  = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        trace[0] = dac_code;
        done_at  = -1;
        n_dones  = 0;
        busy_ok  = busy;
        for (int i = 1; i <= 20; i++) begin
            start = (i == pulse_at);
            @(posedge clk); #1;
            trace[i] = dac_code;
            if (done) begin
                n_dones++;
                if (done_at < 0) done_at = i;
            end
            if (i < 12 && !busy) busy_ok = 1'b0;
            if (i >= 12 && busy) busy_ok = 1'b0;
        end
        start = 1'b0;
    endtask

    task automatic check_seq(input string nm, input int period);
        for (int i = 0; i <= 4 * period; i++) begin
            check($sformatf("%s_dac[%0d]", nm, i), 32'(trace[i]), 32'(seq[i / period]));
        end
    endtask

    initial begin
        int d[4];
        int nd;
        logic prev_done;
        int dbl;

        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int   d[4];
        int   nd;
        logic prev_done;
        int   dbl;

        vecs[0] = '{500, 4'd6};
        vecs[1] = '{1200, 4'd15};
        vecs[2] = '{0, 4'd0};
        for (int k = 0; k < 16; k++) vecs[3 + k] = '{k * 80 + 20, 4'(k)};

        rst    = 1'b1;
        start  = 1'b0;
        start1 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_dac", 32'(dac_code), 0);
        check("rst_result", 32'(result), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_busy1", 32'(busy1), 0);
        check("rst_result1", 32'(result1), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Table-driven conversions: 0.50 V, both rails, then the full sweep.
        for (int v = 0; v < 19; v++) begin
            run_conv(vecs[v].vin_mv, -1);
            check($sformatf("v%0d_result", v), 32'(result), 32'(vecs[v].exp));
            check($sformatf("v%0d_done_lat", v), done_at, 12);
            check($sformatf("v%0d_done_cnt", v), n_dones, 1);
            check($sformatf("v%0d_busy", v), 32'(busy_ok), 1);
            if (v == 0) begin
                seq = '{4'b1000, 4'b0100, 4'b0110, 4'b0111, 4'b0110};
                check_seq("half", 3);
            end else if (v == 1) begin
                seq = '{4'b1000, 4'b1100, 4'b1110, 4'b1111, 4'b1111};
                check_seq("top", 3);
            end else if (v == 2) begin
                seq = '{4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0000};
                check_seq("bot", 3);
            end
        end

        // start pulsed 5 cycles into a conversion must be ignored.
        run_conv(500, 6);
        check("retrig_result", 32'(result), 6);
        check("retrig_done_lat", done_at, 12);
        check("retrig_done_cnt", n_dones, 1);
        check("retrig_busy", 32'(busy_ok), 1);
        seq = '{4'b1000, 4'b0100, 4'b0110, 4'b0111, 4'b0110};
        check_seq("retrig", 3);

        // start held high: completions every 13 edges, done never two cycles in a row.
        vin_mv    = 500;
        start     = 1'b1;
        nd        = 0;
        dbl       = 0;
        prev_done = 1'b0;
        d         = '{-1, -1, -1, -1};
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            if (done) begin
                if (nd < 4) d[nd] = i;
                nd++;
                if (result !== 4'd6) dbl += 100;
                if (prev_done) dbl++;
            end
            prev_done = done;
        end
        start = 1'b0;
        check("held_first_done", d[0], 12);
        check("held_gap0", d[1] - d[0], 13);
        check("held_gap1", d[2] - d[1], 13);
        check("held_gap2", d[3] - d[2], 13);
        check("held_done_cnt", nd, 4);
        check("held_done_width_and_result", dbl, 0);
        begin
            int w = 0;
            while (busy && w < 20) begin
                @(posedge clk); #1;
                w++;
            end
            check("held_drain_idle", 32'(busy), 0);
        end
        @(posedge clk); #1;

        // Reset asserted in cycle 6 of a conversion.
        vin_mv = 500;
        start  = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_dac", 32'(dac_code), 0);
        check("mid_rst_result", 32'(result), 0);
        nd = 0;
        for (int i = 0; i < 20; i++) begin
            if (done) nd++;
            @(posedge clk); #1;
        end
        check("mid_rst_no_done", nd, 0);
        run_conv(1000, -1);
        check("post_rst_result", 32'(result), 12);
        check("post_rst_done_lat", done_at, 12);
        check("post_rst_done_cnt", n_dones, 1);

        // SETTLE_CYCLES=1 variant with cmp inverted on every settle edge.
        vin1_mv = 500;
        start1  = 1'b1;
        @(posedge clk); #1;
        start1   = 1'b0;
        trace[0] = dac_code1;
        done_at  = -1;
        n_dones  = 0;
        busy_ok  = busy1;
        for (int i = 1; i <= 12; i++) begin
            corrupt1 = (i % 2 == 1);
            @(posedge clk); #1;
            trace[i] = dac_code1;
            if (done1) begin
                n_dones++;
                if (done_at < 0) done_at = i;
            end
            if (i < 8 && !busy1) busy_ok = 1'b0;
            if (i >= 8 && busy1) busy_ok = 1'b0;
        end
        corrupt1 = 1'b0;
        check("s1_result", 32'(result1), 6);
        check("s1_done_lat", done_at, 8);
        check("s1_done_cnt", n_dones, 1);
        check("s1_busy", 32'(busy_ok), 1);
        seq = '{4'b1000, 4'b0100, 4'b0110, 4'b0111, 4'b0110};
        check_seq("s1", 2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sar_adc_ctrl.md
Name: sar_adc_ctrl

Overview:
Successive-approximation controller that drives the 4-bit resistor-ladder DAC (dac4x1) code input and consumes a 1-bit comparator decision (analog input vs. DAC output).
- Binary-searches the DAC code MSB-first, with a programmable settle wait per trial bit.
- Presents the converted code on `result` with a one-cycle `done` pulse.
- Together with dac4x1 and a comparator model, it forms the team's 4-bit SAR ADC.

Parameters:
- WIDTH, 4: code width; must match the DAC input width.
- SETTLE_CYCLES, 2: cycles to wait after each DAC code change before sampling `cmp`. Must be >= 1; a value of 0 is illegal.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  conversion request; sampled only in IDLE.
- cmp  input  1  comparator decision: 1 = analog input >= DAC output (keep trial bit); 0 = clear trial bit.
- dac_code  output  WIDTH  code driven to the dac4x1 `in` port.
- busy  output  1  high while a conversion is in progress.
- done  output  1  single-cycle pulse when `result` is updated.
- result  output  WIDTH  last completed conversion; held until the next completion.

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE; dac_code=0, result=0, busy=0, done=0; internal bit index and settle counter cleared. Reset overrides everything, including a conversion in progress.
- States: IDLE, SETTLE, DECIDE.
- IDLE, start=1 at an edge:
  - dac_code <= MSB-only code (1000 for WIDTH=4).
  - bit_idx <= WIDTH-1; cnt <= 0; busy <= 1; go to SETTLE.
- IDLE, start=0: outputs hold. dac_code keeps the last result.
- SETTLE: cnt increments each edge. When cnt == SETTLE_CYCLES-1, go to DECIDE. `cmp` is ignored in this state.
- DECIDE (exactly one cycle), `cmp` sampled at this edge:
  - If cmp=0, clear dac_code[bit_idx]; if cmp=1, keep it.
  - If bit_idx > 0: also set dac_code[bit_idx-1]=1; bit_idx decrements; cnt <= 0; go to SETTLE.
  - If bit_idx == 0: result <= final dac_code (after the bit-0 decision); done <= 1 for one cycle; busy <= 0; go to IDLE. dac_code keeps the final code.
- Latency:
  - Each bit takes SETTLE_CYCLES+1 cycles.
  - `done` is high in the cycle that begins WIDTH*(SETTLE_CYCLES+1) edges after the edge that accepted `start`. Default: 12 edges.
  - `result` and `done` change on the same edge.
- start while busy: ignored, no queuing.
- start high in the DECIDE cycle of bit 0: ignored. It is accepted on the next edge if still high, so back-to-back conversions have one IDLE cycle between them.
- start held high continuously: conversions repeat with one IDLE cycle between each.
- done is never high for more than one consecutive cycle.
- busy=1 exactly from the accept edge until the completion edge.
- dac_code only changes at the accept edge and at DECIDE edges, so it is stable throughout SETTLE.
- Final code equals floor(vin*(2^WIDTH-1)/vref), clamped to 0..2^WIDTH-1. This holds for an ideal comparator and ladder levels i*vref/15.
- Intermediate outputs are not registered separately; no combinational path from `cmp` to any output.

Test Plan:
- Bench setup: dac4x1 + ideal comparator (cmp = vin >= dac out), vref=1.2.
- Basic conversion, vin=0.50:
  - Required dac_code sequence: 1000 -> 0100 -> 0110 -> 0111 -> final 0110.
  - result=0110; done exactly 12 edges after start; busy high for those 12 cycles.
- Rails:
  - vin=1.2 -> result=1111.
  - vin=0.0 -> result=0000.
  - Check cmp-driven bit clears: every trial bit cleared for 0.0, every trial bit kept for 1.2.
- Full sweep: vin=k*0.08+0.02 for k=0..15 -> result=k for each k. done pulses exactly once per conversion.
- Protocol:
  - start pulsed again 5 cycles into a conversion -> ignored; result unchanged from the first conversion.
  - start held high -> completions every 13 cycles.
- Reset mid-conversion: assert rst in cycle 6 of a conversion ->
  - Next edge: busy=0, dac_code=0, result=0, done never pulses for that conversion.
  - A subsequent start converts correctly.
- Parameter variant, SETTLE_CYCLES=1, vin=0.50 -> result=0110 with done 8 edges after start; `cmp` toggled during SETTLE has no effect.
